// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the SDRAM read/write arbiter.
package sdram_arb_pkg;

    localparam int unsigned BURST_LEN_DEF   = 256;
    localparam int unsigned FRAME_WORDS_DEF = 307200;
    localparam int unsigned FIFO_DEPTH_DEF  = 1024;
    localparam int unsigned RD_URGENT_DEF   = 128;

    localparam int unsigned ADDR_W   = 24;
    localparam int unsigned OFFSET_W = 22;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StBusy = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sdram_rw_arbiter_frame_addr_gen.sv
// Per-side frame address generator: word offset, latched bank, deferred frame restart
// and end-of-frame wrap detection.
module frame_addr_gen
    import sdram_arb_pkg::*;
#(
    parameter int unsigned BURST_LEN   = BURST_LEN_DEF,
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
    parameter logic [1:0]  RST_BANK    = 2'b00
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              frame_start_i,
    input  logic [1:0]        bank_i,
    input  logic              inflight_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              frame_done_o
);

    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [1:0]          bank_q, bank_d;
    logic [1:0]          pend_bank_q, pend_bank_d;
    logic                pend_q, pend_d;
    logic                frame_done_q, frame_done_d;
    logic                wrap;

    // Last burst of the frame when the next advance would reach the frame end.
    assign wrap = (32'(offset_q) + BURST_LEN) >= FRAME_WORDS;

    // Next offset/bank: a restart seen mid-burst is parked and replaces the advance.
    always_comb begin
        offset_d     = offset_q;
        bank_d       = bank_q;
        pend_d       = pend_q;
        pend_bank_d  = pend_bank_q;
        frame_done_d = 1'b0;
        if (advance_i) begin
            frame_done_d = wrap;
            if (frame_start_i) begin
                offset_d = '0;
                bank_d   = bank_i;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                offset_d = '0;
                bank_d   = pend_bank_q;
                pend_d   = 1'b0;
            end else if (wrap) begin
                offset_d = '0;
            end else begin
                offset_d = offset_q + OFFSET_W'(BURST_LEN);
            end
        end else if (frame_start_i) begin
            if (inflight_i) begin
                pend_d      = 1'b1;
                pend_bank_d = bank_i;
            end else begin
                offset_d = '0;
                bank_d   = bank_i;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            offset_q     <= '0;
            bank_q       <= RST_BANK;
            pend_q       <= 1'b0;
            pend_bank_q  <= 2'b00;
            frame_done_q <= 1'b0;
        end else begin
            offset_q     <= offset_d;
            bank_q       <= bank_d;
            pend_q       <= pend_d;
            pend_bank_q  <= pend_bank_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign addr_o       = {bank_q, offset_q};
    assign frame_done_o = frame_done_q;

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Arbitrates camera write bursts and VGA read bursts onto one SDRAM command port.
module sdram_rw_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned BURST_LEN   = BURST_LEN_DEF,
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int unsigned RD_URGENT   = RD_URGENT_DEF
) (
    input  logic              clk,
    input  logic              rst_133,
    input  logic [10:0]       wr_level,
    input  logic [10:0]       rd_level,
    input  logic [1:0]        cam_bank,
    input  logic [1:0]        vga_bank,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    input  logic              cmd_ack,
    input  logic              burst_done,
    output logic              cmd_req,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              wr_frame_done,
    output logic              rd_frame_done,
    output logic              busy
);

    arb_state_e        state_q, state_d;
    logic              cmd_req_q, cmd_req_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic              busy_q, busy_d;

    logic              wr_elig, rd_elig, rd_urgent;
    logic              grant_valid, grant_wr;
    logic              wr_inflight, rd_inflight;
    logic              wr_advance, rd_advance;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    assign wr_elig   = 32'(wr_level) >= BURST_LEN;
    assign rd_elig   = 32'(rd_level) <= (FIFO_DEPTH - BURST_LEN);
    assign rd_urgent = rd_elig && (32'(rd_level) < RD_URGENT);

    // Grant selection; cmd_wr_q doubles as the last-granted side (0 = read after reset).
    always_comb begin
        grant_valid = (state_q == StIdle) && (wr_elig || rd_elig);
        if (rd_urgent) begin
            grant_wr = 1'b0;
        end else if (wr_elig && rd_elig) begin
            grant_wr = ~cmd_wr_q;
        end else begin
            grant_wr = wr_elig;
        end
    end

    // A side is in flight from its grant cycle until burst_done, so restarts get parked.
    assign wr_inflight = ((state_q != StIdle) && cmd_wr_q) || (grant_valid && grant_wr);
    assign rd_inflight = ((state_q != StIdle) && !cmd_wr_q) || (grant_valid && !grant_wr);
    assign wr_advance  = (state_q == StBusy) && burst_done && cmd_wr_q;
    assign rd_advance  = (state_q == StBusy) && burst_done && !cmd_wr_q;

    // Next-state and registered command outputs.
    always_comb begin
        state_d    = state_q;
        cmd_req_d  = cmd_req_q;
        cmd_wr_d   = cmd_wr_q;
        cmd_addr_d = cmd_addr_q;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d    = StReq;
                    cmd_req_d  = 1'b1;
                    cmd_wr_d   = grant_wr;
                    cmd_addr_d = grant_wr ? wr_addr : rd_addr;
                end
            end
            StReq: begin
                if (cmd_ack) begin
                    state_d   = StBusy;
                    cmd_req_d = 1'b0;
                end
            end
            StBusy: begin
                if (burst_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                cmd_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // FSM state and output registers; reset drops any outstanding command.
    always_ff @(posedge clk) begin
        if (rst_133) begin
            state_q    <= StIdle;
            cmd_req_q  <= 1'b0;
            cmd_wr_q   <= 1'b0;
            cmd_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_req_q  <= cmd_req_d;
            cmd_wr_q   <= cmd_wr_d;
            cmd_addr_q <= cmd_addr_d;
            busy_q     <= busy_d;
        end
    end

    frame_addr_gen #(
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .RST_BANK    (2'b01)
    ) u_wr_gen (
        .clk_i         (clk),
        .rst_i         (rst_133),
        .frame_start_i (wr_frame_start),
        .bank_i        (cam_bank),
        .inflight_i    (wr_inflight),
        .advance_i     (wr_advance),
        .addr_o        (wr_addr),
        .frame_done_o  (wr_frame_done)
    );

    frame_addr_gen #(
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .RST_BANK    (2'b00)
    ) u_rd_gen (
        .clk_i         (clk),
        .rst_i         (rst_133),
        .frame_start_i (rd_frame_start),
        .bank_i        (vga_bank),
        .inflight_i    (rd_inflight),
        .advance_i     (rd_advance),
        .addr_o        (rd_addr),
        .frame_done_o  (rd_frame_done)
    );

    assign cmd_req  = cmd_req_q;
    assign cmd_wr   = cmd_wr_q;
    assign cmd_addr = cmd_addr_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Self-checking bench for sdram_rw_arbiter against a transaction-level model.
module tb_sdram_rw_arbiter;

    localparam int unsigned BL = 256;
    localparam int unsigned FW = 307200;
    localparam int unsigned FD = 1024;
    localparam int unsigned RU = 128;

    logic        clk = 1'b0;
    logic        rst_133 = 1'b1;
    logic [10:0] wr_level = '0;
    logic [10:0] rd_level = 11'd1000;
    logic [1:0]  cam_bank = '0;
    logic [1:0]  vga_bank = '0;
    logic        wr_frame_start = 1'b0;
    logic        rd_frame_start = 1'b0;
    logic        cmd_ack = 1'b0;
    logic        burst_done = 1'b0;
    logic        cmd_req, cmd_wr, wr_frame_done, rd_frame_done, busy;
    logic [23:0] cmd_addr;

    int checks = 0;
    int errors = 0;

    // Model state, index 1 = write side, 0 = read side.
    int unsigned m_off[2];
    logic [1:0]  m_bank[2];
    bit          m_pend[2];
    logic [1:0]  m_pbank[2];
    bit          m_last_wr;

    always #5 clk = ~clk;

    sdram_rw_arbiter dut (
        .clk            (clk),
        .rst_133        (rst_133),
        .wr_level       (wr_level),
        .rd_level       (rd_level),
        .cam_bank       (cam_bank),
        .vga_bank       (vga_bank),
        .wr_frame_start (wr_frame_start),
        .rd_frame_start (rd_frame_start),
        .cmd_ack        (cmd_ack),
        .burst_done     (burst_done),
        .cmd_req        (cmd_req),
        .cmd_wr         (cmd_wr),
        .cmd_addr       (cmd_addr),
        .wr_frame_done  (wr_frame_done),
        .rd_frame_done  (rd_frame_done),
        .busy           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_off[0] = 0;        m_off[1] = 0;
        m_bank[0] = 2'b00;   m_bank[1] = 2'b01;
        m_pend[0] = 1'b0;    m_pend[1] = 1'b0;
        m_pbank[0] = 2'b00;  m_pbank[1] = 2'b00;
        m_last_wr = 1'b0;
    endtask

    task automatic model_grant(input int wl, input int rl, output bit req, output bit wr);
        bit we, re;
        we  = (wl >= int'(BL));
        re  = (rl <= int'(FD - BL));
        req = we || re;
        if (re && rl < int'(RU)) wr = 1'b0;
        else if (we && re)       wr = !m_last_wr;
        else                     wr = we;
    endtask

    task automatic model_fs(input int side, input logic [1:0] bank, input bit inflight);
        if (inflight) begin
            m_pend[side]  = 1'b1;
            m_pbank[side] = bank;
        end else begin
            m_off[side]  = 0;
            m_bank[side] = bank;
        end
    endtask

    task automatic model_done(input int side, output bit fd);
        fd = (m_off[side] + BL >= FW);
        if (m_pend[side]) begin
            m_off[side]  = 0;
            m_bank[side] = m_pbank[side];
            m_pend[side] = 1'b0;
        end else begin
            m_off[side] = fd ? 0 : m_off[side] + BL;
        end
    endtask

    // Drive one frame_start pulse (cleared by caller) and update the model.
    task automatic fs_drive(input int fs_side, input logic [1:0] fs_bank, input int gside);
        if (fs_side == 1) begin
            wr_frame_start = 1'b1;
            cam_bank       = fs_bank;
        end else begin
            rd_frame_start = 1'b1;
            vga_bank       = fs_bank;
        end
        model_fs(fs_side, fs_bank, fs_side == gside);
    endtask

    task automatic fs_clear();
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        cam_bank       = 2'($urandom);
        vga_bank       = 2'($urandom);
    endtask

    // One arbitration round: grant, optional ack/done delays, optional frame_start.
    task automatic run_xact(input int wl, input int rl, input int ack_dly, input int done_dly,
                            input int fs_side, input logic [1:0] fs_bank, input bit fs_at_done);
        bit exp_req, exp_wr, fd;
        int side;
        logic [23:0] exp_addr;
        model_grant(wl, rl, exp_req, exp_wr);
        side     = exp_wr ? 1 : 0;
        exp_addr = {m_bank[side], 22'(m_off[side])};
        wr_level = 11'(wl);
        rd_level = 11'(rl);
        tick();
        wr_level = '0;
        rd_level = 11'd1000;
        checks++;
        if (cmd_req !== exp_req) begin
            errors++;
            $display("FAIL grant_req: cmd_req=%b expected %b (wl=%0d rl=%0d)",
                     cmd_req, exp_req, wl, rl);
        end
        if (!exp_req) return;
        m_last_wr = exp_wr;
        checks++;
        if (cmd_wr !== exp_wr) begin
            errors++;
            $display("FAIL grant_side: cmd_wr=%b expected %b (wl=%0d rl=%0d)",
                     cmd_wr, exp_wr, wl, rl);
        end
        checks++;
        if (cmd_addr !== exp_addr) begin
            errors++;
            $display("FAIL grant_addr: cmd_addr=%h expected %h", cmd_addr, exp_addr);
        end
        for (int i = 0; i < ack_dly; i++) begin
            burst_done = ($urandom_range(0, 2) == 0);
            tick();
            burst_done = 1'b0;
            checks++;
            if (cmd_req !== 1'b1 || cmd_wr !== exp_wr || cmd_addr !== exp_addr) begin
                errors++;
                $display("FAIL req_hold: req=%b wr=%b addr=%h expected 1 %b %h",
                         cmd_req, cmd_wr, cmd_addr, exp_wr, exp_addr);
            end
        end
        cmd_ack = 1'b1;
        tick();
        cmd_ack = 1'b0;
        checks++;
        if (cmd_req !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ack: cmd_req=%b busy=%b expected 0 1", cmd_req, busy);
        end
        for (int i = 0; i < done_dly; i++) begin
            cmd_ack = ($urandom_range(0, 2) == 0);
            if (i == 0 && fs_side >= 0 && !fs_at_done) fs_drive(fs_side, fs_bank, side);
            tick();
            cmd_ack = 1'b0;
            fs_clear();
            checks++;
            if (busy !== 1'b1 || cmd_req !== 1'b0 || cmd_addr !== exp_addr ||
                wr_frame_done !== 1'b0 || rd_frame_done !== 1'b0) begin
                errors++;
                $display("FAIL busy_hold: busy=%b req=%b addr=%h fd=%b%b expected 1 0 %h 00",
                         busy, cmd_req, cmd_addr, wr_frame_done, rd_frame_done, exp_addr);
            end
        end
        burst_done = 1'b1;
        if (fs_side >= 0 && fs_at_done) fs_drive(fs_side, fs_bank, side);
        tick();
        burst_done = 1'b0;
        fs_clear();
        model_done(side, fd);
        checks++;
        if (busy !== 1'b0 || cmd_req !== 1'b0) begin
            errors++;
            $display("FAIL done_idle: busy=%b cmd_req=%b expected 0 0", busy, cmd_req);
        end
        checks++;
        if (wr_frame_done !== (exp_wr && fd) || rd_frame_done !== (!exp_wr && fd)) begin
            errors++;
            $display("FAIL frame_done: wr=%b rd=%b expected %b %b",
                     wr_frame_done, rd_frame_done, exp_wr && fd, !exp_wr && fd);
        end
        tick();
        checks++;
        if (wr_frame_done !== 1'b0 || rd_frame_done !== 1'b0 || cmd_req !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_pulse: wr=%b rd=%b req=%b expected 0 0 0",
                     wr_frame_done, rd_frame_done, cmd_req);
        end
    endtask

    task automatic test_reset();
        rst_133  = 1'b1;
        wr_level = 11'd1024;
        rd_level = 11'd0;
        cmd_ack  = 1'b1;
        tick();
        tick();
        checks++;
        if (cmd_req !== 1'b0 || cmd_wr !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b wr=%b busy=%b expected 0 0 0",
                     cmd_req, cmd_wr, busy);
        end
        checks++;
        if (cmd_addr !== 24'h0 || wr_frame_done !== 1'b0 || rd_frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: addr=%h fd=%b%b expected 000000 00",
                     cmd_addr, wr_frame_done, rd_frame_done);
        end
        cmd_ack  = 1'b0;
        wr_level = '0;
        rd_level = 11'd1000;
        rst_133  = 1'b0;
        model_reset();
        tick();
        checks++;
        if (cmd_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req=%b busy=%b expected 0 0", cmd_req, busy);
        end
    endtask

    task automatic test_basic_write();
        run_xact(256, 1000, 2, 3, -1, 2'b00, 1'b0);
        run_xact(256, 1000, 0, 1, -1, 2'b00, 1'b0);
    endtask

    task automatic test_round_robin();
        run_xact(300, 600, 1, 1, -1, 2'b00, 1'b0);
        run_xact(300, 600, 0, 2, -1, 2'b00, 1'b0);
    endtask

    task automatic test_urgent();
        run_xact(0, 600, 0, 1, -1, 2'b00, 1'b0);
        run_xact(1024, 100, 1, 1, -1, 2'b00, 1'b0);
    endtask

    task automatic test_frame_start_idle();
        vga_bank       = 2'b11;
        rd_frame_start = 1'b1;
        cmd_ack        = 1'b1;
        burst_done     = 1'b1;
        model_fs(0, 2'b11, 1'b0);
        tick();
        cmd_ack    = 1'b0;
        burst_done = 1'b0;
        fs_clear();
        checks++;
        if (cmd_req !== 1'b0 || busy !== 1'b0 || rd_frame_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: req=%b busy=%b rd_fd=%b expected 0 0 0",
                     cmd_req, busy, rd_frame_done);
        end
        run_xact(0, 500, 0, 1, -1, 2'b00, 1'b0);
    endtask

    task automatic test_frame_start_busy();
        run_xact(256, 1000, 1, 3, 1, 2'b10, 1'b0);
        run_xact(256, 1000, 0, 1, -1, 2'b00, 1'b0);
    endtask

    task automatic test_wrap(input int side, input bit fs_coincident);
        int wl, rl;
        wl = (side == 1) ? 256 : 0;
        rl = (side == 1) ? 1000 : 500;
        while (m_off[side] != FW - BL) run_xact(wl, rl, 0, 0, -1, 2'b00, 1'b0);
        run_xact(wl, rl, 1, 1, fs_coincident ? side : -1, 2'b11, 1'b1);
        run_xact(wl, rl, 0, 0, -1, 2'b00, 1'b0);
    endtask

    task automatic test_reset_busy();
        wr_level = 11'd256;
        rd_level = 11'd1000;
        tick();
        wr_level = '0;
        cmd_ack  = 1'b1;
        tick();
        cmd_ack = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_busy: busy=%b expected 1", busy);
        end
        rst_133 = 1'b1;
        tick();
        rst_133 = 1'b0;
        model_reset();
        checks++;
        if (busy !== 1'b0 || cmd_req !== 1'b0 || cmd_wr !== 1'b0 || cmd_addr !== 24'h0) begin
            errors++;
            $display("FAIL reset_busy: busy=%b req=%b wr=%b addr=%h expected 0 0 0 000000",
                     busy, cmd_req, cmd_wr, cmd_addr);
        end
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        run_xact(256, 1000, 0, 1, -1, 2'b00, 1'b0);
        run_xact(0, 500, 0, 1, -1, 2'b00, 1'b0);
    endtask

    task automatic test_random();
        int r, fs_side, dd;
        for (int n = 0; n < 200; n++) begin
            r       = int'($urandom_range(0, 7));
            fs_side = (r < 2) ? r : -1;
            dd      = int'($urandom_range(1, 4));
            run_xact(int'($urandom_range(0, 1024)), int'($urandom_range(0, 1024)),
                     int'($urandom_range(0, 3)), dd, fs_side, 2'($urandom),
                     1'($urandom));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_write();
        test_round_robin();
        test_urgent();
        test_frame_start_idle();
        test_frame_start_busy();
        test_wrap(1, 1'b0);
        test_wrap(0, 1'b1);
        test_reset_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_rw_arbiter.md
SDRAM_RW_ARBITER -- requirements
Module: sdram_rw_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 256; words per SDRAM burst.
REQ-002 SHALL have parameter FRAME_WORDS, default 307200; words per frame (640x480).
REQ-003 SHALL have parameter FIFO_DEPTH, default 1024; depth of the camera-write and VGA-read FIFOs.
REQ-004 SHALL have parameter RD_URGENT, default 128; read-FIFO level below which a read is urgent.
REQ-005 SHALL have ports, in this order:
- clk  in  1  system clock.
- rst_133  in  1  reset; synchronous, active-high.
- wr_level  in  11  camera write-FIFO fill count.
- rd_level  in  11  VGA read-FIFO fill count.
- cam_bank  in  2  bank for camera writes.
- vga_bank  in  2  bank for VGA reads.
- wr_frame_start  in  1  one-cycle pulse at camera vsync.
- rd_frame_start  in  1  one-cycle pulse at VGA vsync.
- cmd_ack  in  1  SDRAM controller accepted the command.
- burst_done  in  1  one-cycle pulse when the accepted burst is complete.
- cmd_req  out  1  command request.
- cmd_wr  out  1  1 = write burst, 0 = read burst.
- cmd_addr  out  24  {bank[1:0], word offset[21:0]}.
- wr_frame_done  out  1  pulse after the last write burst of a frame.
- rd_frame_done  out  1  pulse after the last read burst of a frame.
- busy  out  1  FSM is not in IDLE.

Function
REQ-006 SHALL implement an FSM with states IDLE, REQ and BUSY:
- IDLE -> REQ when a requester is eligible.
- REQ -> BUSY on cmd_ack.
- BUSY -> IDLE on burst_done.
REQ-007 SHALL treat the write side as eligible when wr_level >= BURST_LEN.
REQ-008 SHALL treat the read side as eligible when rd_level <= FIFO_DEPTH - BURST_LEN.
REQ-009 SHALL grant in this priority order:
- read first if rd_level < RD_URGENT;
- otherwise, if both sides are eligible, the side not granted last (round-robin);
- otherwise, the single eligible side.
REQ-010 SHALL raise cmd_req, cmd_wr and cmd_addr one cycle after the IDLE cycle in which eligibility is evaluated.
REQ-011 SHALL hold cmd_req, cmd_wr and cmd_addr stable from assertion until the cycle cmd_ack is sampled high, and deassert cmd_req the following cycle.
REQ-012 SHALL ignore cmd_ack outside REQ and ignore burst_done outside BUSY.
REQ-013 SHALL keep a 22-bit offset and a 2-bit latched bank per side; cmd_addr = {latched bank, offset}.
REQ-014 SHALL, on burst_done, advance the granted side's offset by BURST_LEN.
REQ-015 SHALL, when offset + BURST_LEN >= FRAME_WORDS at burst_done, wrap that offset to 0 and pulse that side's frame_done for exactly one cycle, coincident with the BUSY->IDLE transition.
REQ-016 SHALL, on wr_frame_start or rd_frame_start, set that side's offset to 0 and latch cam_bank or vga_bank respectively.
REQ-017 SHALL, if a frame_start arrives while that side's burst is in REQ or BUSY, record it as pending and apply it at burst_done, overriding the normal advance.
REQ-018 SHALL, if a frame_start coincides with the wrap of the same side, apply the frame_start result (offset 0, new bank latched) and still pulse frame_done.
REQ-019 SHALL not sample cam_bank or vga_bank except as stated in REQ-016 and REQ-017.

Reset
REQ-020 SHALL, while rst_133 is high at a clk edge:
- set the FSM to IDLE;
- set cmd_req, cmd_wr, wr_frame_done, rd_frame_done and busy to 0;
- set cmd_addr, both offsets and pending flags to 0;
- set the latched write bank to 2'b01 and the latched read bank to 2'b00;
- set last grant to read.
REQ-021 SHALL abandon any outstanding command on reset; recovery of the SDRAM controller is that controller's responsibility.

Structure
REQ-022 SHALL place the FSM state enum, the BURST_LEN/FRAME_WORDS/FIFO_DEPTH/RD_URGENT defaults and the 24-bit address width constant in a shared package, sdram_arb_pkg.
REQ-023 SHALL implement the per-side offset, bank latch, pending flag and wrap logic as one sub-module, frame_addr_gen, instantiated twice (write side, read side).

Verification
REQ-024 SHALL cover these directed scenarios:
- Reset, then wr_level=256, rd_level=1000 -> cmd_req=1, cmd_wr=1, cmd_addr=24'h400000 one cycle later; after cmd_ack and burst_done, write offset = 256.
- Both sides eligible, rd_level=600, last grant = write -> read granted; next arbitration grants write.
- rd_level=100 (urgent), wr_level=1024, last grant = read -> read granted.
- Write offset = 307200-256 at burst_done -> offset returns to 0; wr_frame_done high for exactly 1 cycle.
- wr_frame_start during BUSY with cam_bank=2'b10 -> address unchanged until burst_done; next write cmd_addr = 24'h800000.
- Reset asserted in BUSY -> next cycle: state IDLE, cmd_req=0, all offsets 0.
